// File: rtl/nonce_collector.sv
// nonce_collector
//   Sits downstream of the miner top. It rebuilds the absolute winning nonce
//   for every successful result as {counter, partition} and tags it with the
//   current block epoch. Tagged nonces are queued in a FIFO that the host
//   drains over a ready/valid handshake.
//
//   Optional build macro: NONCE_COLLECTOR_FLUSH_ON_NEW_EN
//     defined   - new_block empties the FIFO. A push in the same cycle is kept
//                 and becomes the only entry.
//     undefined - new_block leaves the FIFO alone. Stale entries drain with
//                 their old rd_tag.
//
// Ports
//   clk           clock
//   rst           asynchronous reset, active low
//   result_valid  one lattice result this cycle
//   success       qualifies result_valid: the hash met the difficulty
//   partition     partition index; forms the low nonce bits
//   new_block     one-cycle strobe announcing a new block header
//   clr_overflow  clears the sticky overflow flag
//   rd_valid      FIFO head entry available
//   rd_ready      host accepts the head entry
//   rd_nonce      head nonce (0 while empty)
//   rd_tag        epoch of the head nonce (0 while empty)
//   count         FIFO occupancy, 0..2**DEPTH_LOG2
//   overflow      sticky: a push was dropped because the FIFO was full
//   exhausted     sticky: the nonce counter wrapped during this block
module nonce_collector #(
  parameter int unsigned COUNTBITS  = 1,
  parameter int unsigned NONCE_BITS = 32,
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned TAGBITS    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  result_valid,
  input  logic                  success,
  input  logic [COUNTBITS-1:0]  partition,
  input  logic                  new_block,
  input  logic                  clr_overflow,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [NONCE_BITS-1:0] rd_nonce,
  output logic [TAGBITS-1:0]    rd_tag,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  exhausted
);

  localparam int unsigned CW = NONCE_BITS - COUNTBITS;
  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [CW-1:0]         counter_q, counter_d;
  logic [TAGBITS-1:0]    epoch_q, epoch_d;
  logic                  exhausted_q, exhausted_d;
  logic                  overflow_q, overflow_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;

  logic [NONCE_BITS-1:0] nonce_mem_q [DEPTH];
  logic [TAGBITS-1:0]    tag_mem_q   [DEPTH];

  logic                  exhausted_eff;
  logic [CW-1:0]         counter_base;
  logic                  accept;
  logic                  push;
  logic [NONCE_BITS-1:0] push_nonce;
  logic                  flush;
  logic                  full;
  logic                  pop;
  logic                  do_push;
  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_idx;

`ifdef NONCE_COLLECTOR_FLUSH_ON_NEW_EN
  assign flush = new_block;
`else
  assign flush = 1'b0;
`endif

  // Result path. new_block is applied first, so a coincident result sees a
  // zeroed counter, a cleared exhausted flag and the incremented epoch.
  always_comb begin
    exhausted_eff = exhausted_q & ~new_block;
    counter_base  = new_block ? '0 : counter_q;
    epoch_d       = new_block ? epoch_q + 1'b1 : epoch_q;
    accept        = result_valid & ~exhausted_eff;
    counter_d     = counter_base;
    exhausted_d   = exhausted_eff;
    if (accept) begin
      counter_d = counter_base + 1'b1;
      if (&counter_base) begin
        exhausted_d = 1'b1;
      end
    end
    push       = accept & success;
    push_nonce = {counter_base, partition};
  end

  // FIFO control.
  always_comb begin
    rd_valid   = (count_q != '0);
    full       = (count_q == FULL_COUNT);
    pop        = rd_valid & rd_ready;
    do_push    = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = wr_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = clr_overflow ? 1'b0 : overflow_q;
    if (flush) begin
      // Discard everything. A coincident push is written to slot 0 and becomes
      // the sole entry; a coincident pop is moot.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      wr_idx   = '0;
      count_d  = '0;
      if (push) begin
        wr_en    = 1'b1;
        wr_ptr_d = DEPTH_LOG2'(1);
        count_d  = (DEPTH_LOG2 + 1)'(1);
      end
    end else begin
      // A pop in the same cycle frees the slot the push needs.
      do_push = push & (~full | pop);
      if (push & full & ~pop) begin
        overflow_d = 1'b1;
      end
      if (do_push) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (!do_push && pop) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      counter_q   <= '0;
      epoch_q     <= '0;
      exhausted_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      counter_q   <= counter_d;
      epoch_q     <= epoch_d;
      exhausted_q <= exhausted_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset: the read port is masked to 0 while empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      nonce_mem_q[wr_idx] <= push_nonce;
      tag_mem_q[wr_idx]   <= epoch_d;
    end
  end

  assign rd_nonce  = rd_valid ? nonce_mem_q[rd_ptr_q] : '0;
  assign rd_tag    = rd_valid ? tag_mem_q[rd_ptr_q] : '0;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign exhausted = exhausted_q;

endmodule
